// File: rtl/op_handler_output_collector_pkg.sv
// Shared types for the op handler return path.
// Purpose: command encoding, handler select enum, FSM state enum and the
// cmd -> handler decode that both the input demux and the output collector
// use, so both ends always agree on which handler owns an op.
package op_handler_output_collector_pkg;

  localparam int CMD_WIDTH = 4;

  // Command codes as presented on the cmd bus.
  localparam logic [CMD_WIDTH-1:0] CMD_G00 = 4'd0;
  localparam logic [CMD_WIDTH-1:0] CMD_G01 = 4'd1;
  localparam logic [CMD_WIDTH-1:0] CMD_G02 = 4'd2;
  localparam logic [CMD_WIDTH-1:0] CMD_G03 = 4'd3;
  localparam logic [CMD_WIDTH-1:0] CMD_G90 = 4'd8;
  localparam logic [CMD_WIDTH-1:0] CMD_G91 = 4'd9;

  typedef enum logic [1:0] {
    HND_LIN   = 2'd0,
    HND_CIRC  = 2'd1,
    HND_DUMMY = 2'd2
  } handler_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Linear moves go to lin, arcs to circ; mode changes and anything
  // unrecognised are absorbed by the dummy handler.
  function automatic handler_sel_t cmd_to_handler(input logic [CMD_WIDTH-1:0] cmd);
    handler_sel_t res;
    case (cmd)
      CMD_G00, CMD_G01: res = HND_LIN;
      CMD_G02, CMD_G03: res = HND_CIRC;
      default:          res = HND_DUMMY;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/op_handler_output_collector_if.sv
// Handler-side and downstream point buses of the output collector.
// Handshake rule (both buses): a point transfers in a cycle where valid and
// ready are both 1 at the rising clock edge; valid must not depend on ready,
// and a producer holds valid and data stable until the transfer happens.
// Signals:
//   hnd_valid/hnd_x/hnd_y/hnd_done : from handlers (0 lin, 1 circ, 2 dummy)
//   hnd_rdy                        : to handlers, at most one bit set
//   out_valid/out_x/out_y          : registered point to downstream
//   out_rdy                        : from downstream
// Modports: slave = the collector, master = handlers plus downstream sink.
interface op_handler_output_collector_if #(
  parameter int POS_WIDTH = 16
);
  logic [2:0]                 hnd_valid;
  logic [2:0][POS_WIDTH-1:0]  hnd_x;
  logic [2:0][POS_WIDTH-1:0]  hnd_y;
  logic [2:0]                 hnd_done;
  logic [2:0]                 hnd_rdy;
  logic                       out_valid;
  logic                       out_rdy;
  logic [POS_WIDTH-1:0]       out_x;
  logic [POS_WIDTH-1:0]       out_y;

  modport slave (
    input  hnd_valid, hnd_x, hnd_y, hnd_done, out_rdy,
    output hnd_rdy, out_valid, out_x, out_y
  );

  modport master (
    output hnd_valid, hnd_x, hnd_y, hnd_done, out_rdy,
    input  hnd_rdy, out_valid, out_x, out_y
  );
endinterface

// File: rtl/op_handler_output_collector_handler_point_reg.sv
// One-entry valid/ready pipeline register for a signed (x,y) point.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   flush             : drop any held point (abort path)
//   in_valid/in_x/in_y: upstream point, in_rdy = upstream ready term
//   out_valid/out_x/out_y, out_rdy : registered downstream point
// Full throughput: a held point can leave and a new one enter in one cycle.
module handler_point_reg #(
  parameter int POS_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [POS_WIDTH-1:0] in_x,
  input  logic [POS_WIDTH-1:0] in_y,
  output logic                 in_rdy,
  output logic                 out_valid,
  output logic [POS_WIDTH-1:0] out_x,
  output logic [POS_WIDTH-1:0] out_y,
  input  logic                 out_rdy
);

  assign in_rdy = !out_valid || out_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_rdy) begin
      out_valid <= 1'b1;
      out_x     <= in_x;
      out_y     <= in_y;
    end else if (out_rdy) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/op_handler_output_collector.sv
// Merges the lin/circ/dummy op handler point streams back onto one
// registered point output. On trigger the owning handler is latched; only
// its points are forwarded and only its done ends the op. After done the
// output register drains, then a single done pulse is issued.
// A watchdog aborts an op whose handler goes quiet for too long.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   trigger, cmd          : op start strobe and command
//   bus (slave)           : handler and downstream point buses
//   cur_x, cur_y          : last point accepted downstream
//   busy                  : op in progress (BUSY or DRAIN)
//   done                  : one-cycle op-complete pulse
//   timeout_err           : sticky watchdog abort flag
//   state_dbg             : current FSM state
module op_handler_output_collector
  import op_handler_output_collector_pkg::*;
#(
  parameter int POS_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 trigger,
  input  logic [CMD_WIDTH-1:0] cmd,
  op_handler_output_collector_if.slave bus,
  output logic [POS_WIDTH-1:0] cur_x,
  output logic [POS_WIDTH-1:0] cur_y,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output state_t               state_dbg
);

  // Wide enough to hold TIMEOUT_CYCLES, and at least one bit when disabled.
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 2);

  state_t         state, state_next;
  handler_sel_t   sel, sel_next;
  logic [WD_W-1:0] wd_cnt, wd_next, wd_inc;
  logic           done_next;
  logic           wd_expire;

  logic                 pr_in_valid;
  logic                 pr_in_rdy;
  logic [POS_WIDTH-1:0] pr_in_x;
  logic [POS_WIDTH-1:0] pr_in_y;
  logic                 up_hs;
  logic                 dn_hs;
  logic                 sel_done;

  handler_point_reg #(
    .POS_WIDTH (POS_WIDTH)
  ) u_point_reg (
    .clk       (clk),
    .reset     (reset),
    .flush     (wd_expire),
    .in_valid  (pr_in_valid),
    .in_x      (pr_in_x),
    .in_y      (pr_in_y),
    .in_rdy    (pr_in_rdy),
    .out_valid (bus.out_valid),
    .out_x     (bus.out_x),
    .out_y     (bus.out_y),
    .out_rdy   (bus.out_rdy)
  );

  // Only the latched handler is ever looked at; the others are don't-care.
  assign pr_in_x     = bus.hnd_x[sel];
  assign pr_in_y     = bus.hnd_y[sel];
  assign sel_done    = bus.hnd_done[sel];
  assign pr_in_valid = (state == ST_BUSY) && bus.hnd_valid[sel];
  assign up_hs       = pr_in_valid && pr_in_rdy;
  assign dn_hs       = bus.out_valid && bus.out_rdy;
  assign wd_inc      = wd_cnt + WD_W'(1);

  always_comb begin
    state_next  = state;
    sel_next    = sel;
    wd_next     = wd_cnt;
    done_next   = 1'b0;
    wd_expire   = 1'b0;
    bus.hnd_rdy = '0;
    case (state)
      ST_IDLE: begin
        if (trigger) begin
          sel_next   = cmd_to_handler(cmd);
          wd_next    = '0;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        bus.hnd_rdy[sel] = pr_in_rdy;
        if (up_hs || sel_done) begin
          wd_next = '0;
        end else begin
          wd_next = wd_inc;
          if ((TIMEOUT_CYCLES != 0) && (wd_inc == WD_W'(TIMEOUT_CYCLES))) begin
            wd_expire = 1'b1;
          end
        end
        // A point offered alongside done is still taken above.
        if (sel_done) begin
          state_next = ST_DRAIN;
        end else if (wd_expire) begin
          state_next = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // Finish once the output register is empty after this cycle.
        if (!bus.out_valid || bus.out_rdy) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      sel         <= HND_DUMMY;
      wd_cnt      <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      cur_x       <= '0;
      cur_y       <= '0;
    end else begin
      state  <= state_next;
      sel    <= sel_next;
      wd_cnt <= wd_next;
      done   <= done_next;
      if (wd_expire) begin
        timeout_err <= 1'b1;
      end
      if (dn_hs) begin
        cur_x <= bus.out_x;
        cur_y <= bus.out_y;
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: doc/op_handler_output_collector.md
# op_handler_output_collector

Return-path counterpart of the processor's handler input demux: it merges the lin, circ and dummy op handlers back onto the single handler interface seen by the processor. On each trigger it latches which handler owns the op and forwards only that handler's point stream through a registered valid/ready stage. It tracks the last committed pen position and returns a single `done` pulse once the op has fully drained. A watchdog aborts a handler that stalls.

## Interface
- `POS_WIDTH`, 16: signed coordinate width.
- `TIMEOUT_CYCLES`, 65535: idle-cycle limit in BUSY; 0 disables the watchdog.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `trigger` in 1: op start, same strobe that drives the input demux.
- `cmd` in `Op_PKG` cmd width: current op command.
- `hnd_valid` in [2:0]: per-handler point valid; index 0 lin, 1 circ, 2 dummy.
- `hnd_x`, `hnd_y` in [2:0][POS_WIDTH-1:0]: per-handler point, signed.
- `hnd_done` in [2:0]: per-handler op-complete level/pulse.
- `hnd_rdy` out [2:0]: per-handler ready; only the selected bit may be 1.
- `out_valid` out 1, `out_rdy` in 1: downstream point handshake.
- `out_x`, `out_y` out POS_WIDTH: registered point.
- `cur_x`, `cur_y` out POS_WIDTH: last point accepted downstream.
- `busy` out 1: op in progress (BUSY or DRAIN).
- `done` out 1: one-cycle op-complete pulse.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- Decode: G00/G01 -> lin (0); G02/G03 -> circ (1); G90/G91 and any other cmd -> dummy (2).
- States: IDLE, BUSY, DRAIN.
- IDLE: `trigger`=1 latches `sel` from `cmd`, clears watchdog, goes to BUSY. `hnd_rdy`=0.
- BUSY: `trigger` ignored. `hnd_rdy[sel]` = `!out_valid || out_rdy`, and other bits are 0. A `hnd_valid[sel] && hnd_rdy[sel]` handshake loads `out_x/out_y` and sets `out_valid`. Valids from non-selected handlers are ignored.
- BUSY with `hnd_done[sel]`=1: go to DRAIN. A point offered in the same cycle is still accepted. `done` from non-selected handlers is ignored.
- DRAIN: `hnd_rdy`=0. When the output register is empty after this cycle (`!out_valid`, or `out_valid && out_rdy`), the next cycle has `done`=1 and the state is IDLE.
- Output stage: `out_valid` clears on `out_valid && out_rdy` unless it is reloaded in the same cycle. Throughput is 1 point/cycle.
- Position: `cur_x/cur_y` <= `out_x/out_y` on each downstream handshake. They are not modified by trigger or abort.
- Watchdog: counts BUSY cycles with neither a handler handshake nor `hnd_done[sel]`; either event resets it. When the count reaches `TIMEOUT_CYCLES`: `timeout_err`<=1 (sticky), state goes to IDLE, `out_valid` is cleared, and no `done` is issued.
- Reset in any state: all registers take their reset values, the state goes to IDLE, and any pending point is discarded.

## Timing
- Reset values: `hnd_rdy`=0, `out_valid`=0, `out_x/out_y`=0, `cur_x/cur_y`=0, `busy`=0, `done`=0, `timeout_err`=0, `sel`=dummy, watchdog=0.
- Trigger at cycle t: `busy`=1 and `hnd_rdy[sel]`=1 from t+1.
- Handler handshake at t: `out_valid`=1 with that point at t+1. Latency is 1.
- `hnd_done[sel]` at t with an empty output register: DRAIN at t+1, `done`=1 and `busy`=0 at t+2. A trigger at t+2 is accepted.
- `done` is never high in the same cycle as `busy`.
- Watchdog expiry at the end of cycle t (the count reaches `TIMEOUT_CYCLES` that cycle): `timeout_err`=1 and IDLE at t+1.

## Structure
- `Op_PKG` additions: enum `HandlerSel_t` {HND_LIN=0, HND_CIRC=1, HND_DUMMY=2}, plus function `cmd_to_handler(cmd)`. The input demux uses the same function so both ends decode identically.
- Sub-module `handler_point_reg`: a one-entry valid/ready pipeline register parameterized by POS_WIDTH. It produces `out_*` and the upstream ready term.
- The FSM, `sel` register, watchdog and position registers live in the top module.

## Test plan
- Trigger with G01; lin sends (5,-3),(6,-2) with `out_rdy`=1, then `hnd_done[0]` -> `out_*` shows each point 1 cycle later, `cur`=(6,-2), a single `done` pulse 2 cycles after `hnd_done`.
- Trigger with G02 while lin and dummy toggle `hnd_valid`/`hnd_done` -> only circ points appear, `hnd_rdy`=3'b010, and stray done does not end the op.
- Circ streams 4 points with `out_rdy` held 0 for 3 cycles, then 1 -> no loss or duplication, `hnd_rdy[1]` low while stalled, order preserved.
- Trigger with G90, dummy asserts `hnd_done[2]` the next cycle with no points -> `done` pulses, `cur` unchanged, no `out_valid`.
- `TIMEOUT_CYCLES`=8, trigger G00, lin silent -> `timeout_err`=1 after 8 idle BUSY cycles, IDLE, no `done`; a later G01 op still completes normally with `timeout_err` still 1.
- `reset` asserted in DRAIN with a pending point -> the next cycle has all outputs at reset values, state IDLE, and the point is dropped.
